// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the loader state encoding and the fixed word geometry used by the
// loader FSM and its byte packer.
package instr_loader_pkg;

   // Loader FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR_HI  = 3'd1,
      ST_HDR_LO  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_WRITE   = 3'd4,
      ST_CHECK   = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } loader_state_t;

   // Instruction words are always assembled from four stream bytes.
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_word_packer.sv
// Byte-to-word shift packer: assembles stream bytes MSB-first into one instruction word.
// Latency: word updates the cycle after each shift_en; word_full flags the shift that completes it.
// Backpressure: none; the caller only pulses shift_en on accepted bytes.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clear         synchronous clear of word and byte counter
//   shift_en      shift byte_in into the low byte of word
//   byte_in       stream byte
//   word          packed word (first byte ends up in the top byte)
//   word_full     combinational: this shift delivers the last byte of a word
module instr_loader_word_packer
   import instr_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word     <= '0;
         byte_cnt <= 2'd0;
      end else if (shift_en) begin
         word     <= {word[WORD_W-9:0], byte_in};
         byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the fourth byte
      end
   end

   assign word_full = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Boot loader: packs a byte stream into instruction words, writes them from address 0, checks an XOR sum, releases the core.
// Latency: imem_we the cycle after a word's 4th byte; done/error/cpu_reset the cycle after the checksum byte.
// Backpressure: in_ready drops for the single write cycle per word and in DONE/ERROR; unaccepted bytes must be held.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_data      stream byte from host; in_ready accepts it
//   imem_we/addr/wdata    one-cycle word write into instruction memory
//   cpu_reset             holds the core in reset until a verified load completes
//   busy                  load in progress (header through checksum)
//   done/error            sticky completion / failure (mutually exclusive)
//   words_loaded          number of words written so far
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int WORD_W    = 32,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   loader_state_t state;
   logic [15:0]   cnt;          // header word count N
   logic [7:0]    chk;          // running XOR of payload bytes
   logic          xfer;
   logic [15:0]   cnt_rx;       // full count as it completes in HDR_LO
   logic [15:0]   words_next;
   logic          shift_en;
   logic          pk_clear;
   logic          word_full;
   logic [WORD_W-1:0] pk_word;

   assign xfer       = in_valid && in_ready;
   assign cnt_rx     = {cnt[15:8], in_data};
   assign words_next = words_loaded + 16'd1;
   assign shift_en   = xfer && (state == ST_PAYLOAD);
   assign pk_clear   = (state == ST_IDLE);

   // The packer register doubles as the write-data register: it holds the
   // complete word throughout the WRITE cycle and is zero out of reset.
   assign imem_wdata = pk_word;

   instr_loader_word_packer #(
      .WORD_W (WORD_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (pk_clear),
      .shift_en  (shift_en),
      .byte_in   (in_data),
      .word      (pk_word),
      .word_full (word_full)
   );

   // Outputs are registered: each transition also sets the output values
   // that belong to the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= 16'd0;
         chk          <= 8'd0;
         in_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         cpu_reset    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_HDR_HI;
               in_ready <= 1'b1;
               busy     <= 1'b1;
            end
            ST_HDR_HI: begin
               if (xfer) begin
                  cnt[15:8] <= in_data;
                  state     <= ST_HDR_LO;
               end
            end
            ST_HDR_LO: begin
               if (xfer) begin
                  cnt <= cnt_rx;
                  if (cnt_rx > 16'(MAX_WORDS)) begin
                     state    <= ST_ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                  end else if (cnt_rx == 16'd0) begin
                     state <= ST_CHECK;
                  end else begin
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (xfer) begin
                  chk <= chk ^ in_data;
                  if (word_full) begin
                     state     <= ST_WRITE;
                     in_ready  <= 1'b0;
                     imem_we   <= 1'b1;
                     imem_addr <= words_loaded[ADDR_W-1:0];
                  end
               end
            end
            ST_WRITE: begin
               imem_we      <= 1'b0;
               in_ready     <= 1'b1;
               words_loaded <= words_next;
               state        <= (words_next == cnt) ? ST_CHECK : ST_PAYLOAD;
            end
            ST_CHECK: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_data == chk) begin
                     state     <= ST_DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            // Terminal: only reset leaves DONE or ERROR.
            ST_DONE:  state <= ST_DONE;
            ST_ERROR: state <= ST_ERROR;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: streams images, expected writes are queued from a stream-level model.
module tb_instr_loader;

   localparam int ADDR_W    = 16;
   localparam int WORD_W    = 32;
   localparam int MAX_WORDS = 256;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;
   logic [15:0]       words_loaded;

   instr_loader #(
      .ADDR_W    (ADDR_W),
      .WORD_W    (WORD_W),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_reset    (cpu_reset),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] stim[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         bnr      = 0;   // cycles with busy=1 and in_ready=0

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the expected write for every imem_we strobe.
   always @(negedge clk) begin
      wr_t w;
      if (!reset) begin
         if (busy && !in_ready) bnr++;
         check("done_error_exclusive", 64'(done & error), 64'd0);
         if (imem_we) begin
            check("ready_low_on_write", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: actual addr=%0h data=%0h required no write",
                        imem_addr, imem_wdata);
            end else begin
               w = exp_q.pop_front();
               check("imem_addr", 64'(imem_addr), 64'(w.addr));
               check("imem_wdata", 64'(imem_wdata), 64'(w.data));
            end
         end
      end
   end

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_imem_we", 64'(imem_we), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);
      check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_words_loaded", 64'(words_loaded), 64'd0);
      reset = 1'b0;
   endtask

   // Offer one byte after a random idle gap; returns once it is accepted
   // (time is then #1 after the accepting edge). in_valid stays high.
   task automatic send_byte(input logic [7:0] b, input int maxgap, output bit ok);
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      if (g > 0) begin
         in_valid = 1'b0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      ok       = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: actual no accept in 200 cycles required in_ready for byte %0h", b);
      end
   endtask

   // Build a well-formed image of n random words; bad corrupts the checksum byte.
   task automatic build_stream(input int n, input bit bad);
      logic [31:0] w;
      logic [7:0]  x;
      stim = {};
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      x = 8'd0;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         for (int k = 3; k >= 0; k--) begin
            stim.push_back(w[8*k +: 8]);
            x = x ^ w[8*k +: 8];
         end
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      stim.push_back(x);
   endtask

   // Reference model: parse the stream by its format rules, queue the writes
   // that the sent prefix completes, then drive it and check the outcome.
   task automatic run_image(input logic [7:0] s[$], input int limit_in, input int maxgap);
      int         n;
      bit         oversize;
      int         consumed;
      int         limit;
      int         n_wr;
      logic [7:0] x;
      bit         exp_done;
      bit         ok;
      n        = {16'd0, s[0], s[1]};
      oversize = (n > MAX_WORDS);
      consumed = oversize ? 2 : 2 + 4 * n + 1;
      limit    = (limit_in < 0 || limit_in > consumed) ? consumed : limit_in;
      x        = 8'd0;
      exp_done = 1'b0;
      n_wr     = 0;
      if (!oversize) begin
         for (int i = 0; i < 4 * n; i++) x = x ^ s[2 + i];
         exp_done = (s[2 + 4 * n] == x);
         for (int i = 0; i < n; i++) begin
            if (2 + 4 * (i + 1) <= limit) begin
               exp_q.push_back({16'(i), s[2 + 4*i], s[3 + 4*i], s[4 + 4*i], s[5 + 4*i]});
               n_wr++;
            end
         end
      end
      do_reset();
      bnr = 0;
      for (int k = 0; k < limit; k++) begin
         send_byte(s[k], maxgap, ok);
         if (!ok) begin
            in_valid = 1'b0;
            return;
         end
         // Write strobe must follow the last byte of each word by one cycle.
         if (!oversize && k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3)
            check("we_latency", 64'(imem_we), 64'd1);
      end
      in_valid = 1'b0;
      if (limit == consumed) begin
         check("done", 64'(done), 64'(exp_done));
         check("error", 64'(error), 64'(!exp_done));
         check("cpu_reset", 64'(cpu_reset), 64'(!exp_done));
         check("ready_after_end", 64'(in_ready), 64'd0);
         check("busy_after_end", 64'(busy), 64'd0);
         repeat (4) begin
            @(posedge clk);
            #1;
         end
         check("words_loaded", 64'(words_loaded), oversize ? 64'd0 : 64'(n));
         check("pending_writes", 64'(exp_q.size()), 64'd0);
         check("write_stall_cycles", 64'(bnr), 64'(n_wr));
         check("done_sticky", 64'(done), 64'(exp_done));
         check("error_sticky", 64'(error), 64'(!exp_done));
      end
   endtask

   initial begin
      // 1: single word, good checksum
      stim = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      run_image(stim, -1, 2);
      // 2: three words, in_valid held high
      build_stream(3, 1'b0);
      run_image(stim, -1, 0);
      // 3: bad checksum; word still written
      stim = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
      run_image(stim, -1, 2);
      // 4: empty image, good and bad checksum
      stim = {8'h00, 8'h00, 8'h00};
      run_image(stim, -1, 1);
      stim = {8'h00, 8'h00, 8'h01};
      run_image(stim, -1, 1);
      // 5: oversize header, then largest legal image
      stim = {8'h01, 8'h01};
      run_image(stim, -1, 2);
      build_stream(MAX_WORDS, 1'b0);
      run_image(stim, -1, 0);
      // 6: reset after six payload bytes, then a fresh single-word load
      build_stream(2, 1'b0);
      run_image(stim, 8, 3);
      @(posedge clk);
      #1;
      check("partial_writes_drained", 64'(exp_q.size()), 64'd0);
      build_stream(1, 1'b0);
      run_image(stim, -1, 3);
      // Random images with random gaps and occasional corrupt checksums
      for (int r = 0; r < 10; r++) begin
         build_stream(int'($urandom_range(1, 6)), ($urandom_range(0, 2) == 0));
         run_image(stim, -1, int'($urandom_range(0, 3)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
